// File: rtl/cmd_sched_if.sv
// Requester-side command bus: per-requester valid and command word, one-hot ready back.
interface cmd_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]    req_ready;

    modport master (output req_valid, output req_cmd, input  req_ready);
    modport slave  (input  req_valid, input  req_cmd, output req_ready);
endinterface

// File: rtl/cmd_sched.sv
// Command scheduler: round-robin arbitration of NUM_REQ requesters onto one executor
// that decodes and runs BANK / OUT commands and reports malformed words.
module cmd_sched #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cmd_sched_if.slave        req,
    output logic [31:0]       bank_val,
    output logic [3:0]        bank_wr_stb,
    output logic [4:0]        out_sel,
    output logic              out_upd,
    output logic              err,
    output logic [3:0]        err_cmd_id,
    output logic              busy
);
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_BANK = 4;

    typedef enum logic [1:0] {IDLE, EXEC_BANK, EXEC_OUT, EXEC_ERR} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [3:0]       pend_en;
    logic [7:0]       bank_data;
    logic [4:0]       out_data;
    logic [3:0]       cmd_id;

    logic             grant_found_c;
    logic [PTR_W-1:0] grant_idx_c;
    logic [PTR_W:0]   cand_c;
    logic [31:0]      grant_cmd_c;
    logic [NUM_REQ-1:0] ready_c;
    logic             bank_ok_c;
    logic             out_ok_c;
    logic [3:0]       low_bit_c;
    logic             last_c;
    logic [PTR_W-1:0] next_ptr_c;

    // First valid requester at or after rr_ptr, scanning upward with wrap
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand_c >= (PTR_W+1)'(NUM_REQ))
                cand_c = cand_c - (PTR_W+1)'(NUM_REQ);
            if (!grant_found_c && req.req_valid[cand_c[PTR_W-1:0]]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = cand_c[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_cmd_c = '0;
        ready_c     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_c == PTR_W'(i)) begin
                grant_cmd_c = req.req_cmd[32*i +: 32];
                ready_c[i]  = (state == IDLE) && grant_found_c;
            end
        end
    end

    assign req.req_ready = ready_c;

    assign bank_ok_c  = (grant_cmd_c[31:28] == 4'd0) && (grant_cmd_c[7:4] == 4'd0) &&
                        (grant_cmd_c[27:16] == 12'd0);
    assign out_ok_c   = (grant_cmd_c[31:28] == 4'd1) && (grant_cmd_c[27:5] == 23'd0);
    assign low_bit_c  = pend_en & 4'(~pend_en + 4'd1);
    assign last_c     = (pend_en & 4'(pend_en - 4'd1)) == 4'd0;
    assign next_ptr_c = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);

    // Executor FSM; strobes default low so every pulse is exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            pend_en     <= '0;
            bank_data   <= '0;
            out_data    <= '0;
            cmd_id      <= '0;
            bank_val    <= '0;
            bank_wr_stb <= '0;
            out_sel     <= '0;
            out_upd     <= 1'b0;
            err         <= 1'b0;
            err_cmd_id  <= '0;
            busy        <= 1'b0;
        end else begin
            bank_wr_stb <= '0;
            out_upd     <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_found_c) begin
                        rr_ptr    <= next_ptr_c;
                        pend_en   <= grant_cmd_c[3:0];
                        bank_data <= grant_cmd_c[15:8];
                        out_data  <= grant_cmd_c[4:0];
                        cmd_id    <= grant_cmd_c[31:28];
                        busy      <= 1'b1;
                        if (bank_ok_c)     state <= EXEC_BANK;
                        else if (out_ok_c) state <= EXEC_OUT;
                        else               state <= EXEC_ERR;
                    end
                end
                EXEC_BANK: begin
                    for (int unsigned i = 0; i < NUM_BANK; i++) begin
                        if (low_bit_c[i]) bank_val[8*i +: 8] <= bank_data;
                    end
                    bank_wr_stb <= low_bit_c;
                    pend_en     <= pend_en & ~low_bit_c;
                    if (last_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                EXEC_OUT: begin
                    out_sel <= out_data;
                    out_upd <= 1'b1;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                EXEC_ERR: begin
                    err        <= 1'b1;
                    err_cmd_id <= cmd_id;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cmd_sched.md
# cmd_sched

Command scheduler for the task-command path. It shares one command executor between `NUM_REQ` task requesters using a round-robin valid/ready arbiter. Each accepted 32-bit command word is decoded per the command ICD (ID in [31:28]) and executed. BANK commands are sequenced as one register write per enabled bank per cycle. OUT commands update the output selector. Malformed words are reported and discarded.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester command valid.
- `req_cmd`  in  32*NUM_REQ  command word; requester i occupies bits [32*i+31:32*i].
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational.
- `bank_val`  out  32  bank registers; bank i at [8*i+7:8*i].
- `bank_wr_stb`  out  4  one-cycle pulse per bank updated.
- `out_sel`  out  5  current output select.
- `out_upd`  out  1  one-cycle pulse when `out_sel` is written.
- `err`  out  1  one-cycle pulse on discarded command.
- `err_cmd_id`  out  4  ID field of the last discarded command.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, EXEC_BANK, EXEC_OUT, EXEC_ERR.
- **IDLE:** if any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, scanning upward with wrap. Drive `req_ready[g]=1` combinationally. The handshake occurs in that cycle and the command word is latched. `rr_ptr` becomes (g+1) mod NUM_REQ.
- **Decode of the latched word:**
  - ID=0 (BANK) with bits [7:4] and [27:16] zero → EXEC_BANK.
  - ID=1 (OUT) with bits [27:5] zero → EXEC_OUT.
  - Anything else → EXEC_ERR.
- **EXEC_BANK:**
  - Each cycle, service the lowest still-pending bit of en[3:0]: `bank_val[i]` <= val[15:8], `bank_wr_stb[i]` <= 1, then clear that bit.
  - Return to IDLE after the cycle that services the last bit.
  - en=0 spends exactly one cycle, writes nothing, raises no error.
- **EXEC_OUT:** one cycle; `out_sel` <= cmd[4:0], `out_upd` <= 1; then IDLE.
- **EXEC_ERR:** one cycle; `err` <= 1, `err_cmd_id` <= cmd[31:28]; then IDLE. No bank or out state changes.
- `req_ready` is all-zero outside IDLE. Requesters must hold valid and cmd until accepted; violations are not detected.
- **Reset:** asynchronous, active-low; takes effect immediately.
  - All outputs go to 0: `bank_val`=0, `out_sel`=0, strobes, `err`, `err_cmd_id`, `busy`.
  - State returns to IDLE and `rr_ptr` to 0.
  - Pending bank writes are abandoned and never issued after release.

## Timing
- **Handshake:** cycle C0. EXEC occupies C1..Cn. IDLE returns in cycle Cn+1, and the next handshake may occur in that same cycle.
- **Register updates:** strobes and data are registered; each becomes visible in the cycle after the EXEC cycle that decided it.
  - BANK with k bits set: strobes in C2..C(k+1), one bank per cycle, ascending index; IDLE again at C(k+1).
  - OUT and ERR: pulse in C2; IDLE at C2.
- **Throughput:** at most one command per 2 cycles. All strobes are exactly one cycle wide.
- **Arbitration:** `rr_ptr` updates only on a handshake, so no requester waits more than NUM_REQ grants.

## Test plan
- Requester 0 sends 0x0000_AB05 → `req_ready[0]` in C0. `bank_wr_stb`=0x1 in C2 and 0x4 in C3. Banks 0 and 2 read 0xAB, banks 1 and 3 stay 0. `busy` high C1–C2; next grant possible in C3.
- Requester 2 sends 0x1000_0013 → `out_sel`=0x13 with `out_upd` pulse in C2. No bank strobe.
- All four requesters continuously valid with distinct OUT commands → grant order 0,1,2,3,0, one grant every 2 cycles. `out_sel` follows the issued values in that order.
- Errors: 0x2000_0000 → `err` pulse in C2, `err_cmd_id`=2. 0x0001_FF01 (reserved bit 16 set) → `err`, `err_cmd_id`=0, bank 0 unchanged.
- 0x0000_5500 (en=0) → one EXEC cycle, no strobes, no `err`, IDLE in C2.
- 0x0000_770F, then `rst_n` low during C3 → all outputs 0 immediately. Banks 2 and 3 are never strobed after release, and the first grant after release goes to requester 0.
